// File: rtl/alu_issue_if.sv
// Handshake and payload bundle for the ALU issue stage.
//   in_*   : upstream (register read) -> stage, valid/ready + instruction/pc/operands
//   out_*  : stage -> execute, valid/ready + decoded ALU op, operands and flags
// master : the environment side (drives in_* payload and out_ready)
// slave  : the issue stage itself
interface alu_issue_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;

  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_alu_c;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic            out_word;
  logic [4:0]      out_rd;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_alu_c, out_a, out_b, out_word, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_alu_c, out_a, out_b, out_word, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV64I decode/issue stage in front of the 64-bit ALU.
// Decodes one integer instruction per accepted handshake into an ALU op code and
// final A/B operands, then holds it in a 2-entry skid buffer (main M drives the
// outputs, skid S catches the one extra beat) so in_ready is a plain flop output.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   flush  synchronous kill of both buffered entries (and any same-cycle accept)
//   bus    alu_issue_if.slave: in_* handshake/payload, out_* handshake/decoded op
// Only XLEN = 64 is supported.
module alu_issue_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  alu_issue_if.slave   bus
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e         alu_c;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            word;
    logic [4:0]      rd;
    logic            illegal;
  } entry_t;

  // ---------------- decode ----------------
  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [5:0]      f6;
  logic [XLEN-1:0] imm_i, imm_u, rs1_zw, rs1_sw, rs2_w;
  logic            ill;
  entry_t          dec;

  always_comb begin
    opcode = bus.in_instr[6:0];
    f3     = bus.in_instr[14:12];
    f7     = bus.in_instr[31:25];
    f6     = bus.in_instr[31:26];
    imm_i  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    imm_u  = {{(XLEN-32){bus.in_instr[31]}}, bus.in_instr[31:12], 12'b0};
    rs1_zw = {{(XLEN-32){1'b0}}, bus.in_rs1[31:0]};
    rs1_sw = {{(XLEN-32){bus.in_rs1[31]}}, bus.in_rs1[31:0]};
    // W-form shift amounts are 5 bits: drop bit 5 of the register shamt
    rs2_w  = {bus.in_rs2[XLEN-1:6], 1'b0, bus.in_rs2[4:0]};
    ill    = 1'b0;
    dec    = '0;
    dec.rd = bus.in_instr[11:7];
    dec.a  = bus.in_rs1;
    dec.b  = bus.in_rs2;
    case (opcode)
      7'b0110011: begin // OP
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: dec.alu_c = ALU_ADD;
            3'd1: dec.alu_c = ALU_SLL;
            3'd2: dec.alu_c = ALU_SLT;
            3'd3: dec.alu_c = ALU_SLTU;
            3'd4: dec.alu_c = ALU_XOR;
            3'd5: dec.alu_c = ALU_SRL;
            3'd6: dec.alu_c = ALU_OR;
            default: dec.alu_c = ALU_AND;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) dec.alu_c = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5)    dec.alu_c = ALU_SRA;
        else ill = 1'b1;
      end
      7'b0010011: begin // OP-IMM
        dec.b = imm_i;
        case (f3)
          3'd0: dec.alu_c = ALU_ADD;
          3'd2: dec.alu_c = ALU_SLT;
          3'd3: dec.alu_c = ALU_SLTU;
          3'd4: dec.alu_c = ALU_XOR;
          3'd6: dec.alu_c = ALU_OR;
          3'd7: dec.alu_c = ALU_AND;
          3'd1: begin
            dec.b     = {{(XLEN-6){1'b0}}, bus.in_instr[25:20]};
            dec.alu_c = ALU_SLL;
            ill       = (f6 != 6'h00);
          end
          default: begin // 3'd5
            dec.b = {{(XLEN-6){1'b0}}, bus.in_instr[25:20]};
            if (f6 == 6'h00)      dec.alu_c = ALU_SRL;
            else if (f6 == 6'h10) dec.alu_c = ALU_SRA;
            else ill = 1'b1;
          end
        endcase
      end
      7'b0111011: begin // OP-32
        dec.word = 1'b1;
        case (f3)
          3'd0: begin
            if (f7 == 7'h00)      dec.alu_c = ALU_ADD;
            else if (f7 == 7'h20) dec.alu_c = ALU_SUB;
            else ill = 1'b1;
          end
          3'd1: begin
            dec.b     = rs2_w;
            dec.alu_c = ALU_SLL;
            ill       = (f7 != 7'h00);
          end
          3'd5: begin
            dec.b = rs2_w;
            if (f7 == 7'h00) begin
              dec.alu_c = ALU_SRL;
              dec.a     = rs1_zw;
            end else if (f7 == 7'h20) begin
              dec.alu_c = ALU_SRA;
              dec.a     = rs1_sw;
            end else ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      7'b0011011: begin // OP-IMM-32
        dec.word = 1'b1;
        dec.b    = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
        case (f3)
          3'd0: begin
            dec.b     = imm_i;
            dec.alu_c = ALU_ADD;
          end
          3'd1: begin
            dec.alu_c = ALU_SLL;
            ill       = (f7 != 7'h00);
          end
          3'd5: begin
            if (f7 == 7'h00) begin
              dec.alu_c = ALU_SRL;
              dec.a     = rs1_zw;
            end else if (f7 == 7'h20) begin
              dec.alu_c = ALU_SRA;
              dec.a     = rs1_sw;
            end else ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      7'b0110111: begin // LUI
        dec.alu_c = ALU_ADD;
        dec.a     = '0;
        dec.b     = imm_u;
      end
      7'b0010111: begin // AUIPC
        dec.alu_c = ALU_ADD;
        dec.a     = bus.in_pc;
        dec.b     = imm_u;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec.alu_c   = ALU_ADD;
      dec.a       = '0;
      dec.b       = '0;
      dec.word    = 1'b0;
      dec.illegal = 1'b1;
    end
  end

  // ---------------- skid buffer ----------------
  logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  entry_t m_q, m_d, s_q, s_d;
  logic   accept, pop;

  always_comb begin
    accept    = bus.in_valid & ~s_valid_q;
    pop       = m_valid_q & bus.out_ready;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_d       = m_q;
    s_d       = s_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (pop && s_valid_q) begin
      // S is full only while in_ready=0, so no accept can coincide here
      m_d       = s_q;
      s_valid_d = 1'b0;
    end else if (accept && (!m_valid_q || pop)) begin
      m_d       = dec;
      m_valid_d = 1'b1;
    end else if (accept) begin
      s_d       = dec;
      s_valid_d = 1'b1;
    end else if (pop) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_q       <= '0;
      s_q       <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_q       <= m_d;
      s_q       <= s_d;
    end
  end

  assign bus.in_ready    = ~s_valid_q;
  assign bus.out_valid   = m_valid_q;
  assign bus.out_alu_c   = m_q.alu_c;
  assign bus.out_a       = m_q.a;
  assign bus.out_b       = m_q.b;
  assign bus.out_word    = m_q.word;
  assign bus.out_rd      = m_q.rd;
  assign bus.out_illegal = m_q.illegal;

endmodule
